hi_lo_muldiv_controller: RTL

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO write port of Register_File.

---
 rtl/hi_lo_muldiv_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hi_lo_muldiv_controller.sv
// HI/LO multiply/divide sequencer: captures operands at issue, iterates a
// shift-add multiplier or restoring divider, applies sign fix-up and issues
// a single-cycle HI/LO write pulse. Stalls the pipeline while an op is in
// flight and the decode stage wants HI/LO or tries to issue another op.
//
// Handshake: start is a request that is only honoured in IDLE; while busy the
// request is dropped and stall is raised so the issuing instruction holds,
// so the op is taken on the first IDLE cycle it is still presented.
module hi_lo_muldiv_controller #(
  parameter int BITS_PER_CYCLE = 1  // legal values: 1, 2, 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        hi_lo_read_request,
  output logic        busy,
  output logic        stall,
  output logic        hi_lo_register_write_enable,
  output logic [31:0] HI_write_data,
  output logic [31:0] LO_write_data,
  output logic        div_by_zero,
  output logic [1:0]  state_dbg
);

  localparam int         ITER = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_q;       // negate product (MULT) or quotient (DIV)
  logic        rem_neg_q;   // remainder takes a negative dividend's sign
  logic [31:0] opb_q;       // |multiplicand| for mul, |divisor| for div
  logic [31:0] acc_hi_q;    // product high half / partial remainder
  logic [31:0] acc_lo_q;    // multiplier bits / dividend-then-quotient
  logic        we_q;
  logic        dbz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        is_dbz;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
  assign mag_b     = (signed_op && operand_b[31]) ? (32'd0 - operand_b) : operand_b;
  assign is_dbz    = op[1] && (operand_b == 32'd0);

  // One compute cycle: BITS_PER_CYCLE unrolled shift-add or restoring-divide steps.
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [32:0] sum_w;
  logic [32:0] rem_w;
  always_comb begin
    step_hi = acc_hi_q;
    step_lo = acc_lo_q;
    sum_w   = '0;
    rem_w   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div_q) begin
        rem_w   = {step_hi, step_lo[31]};
        step_lo = {step_lo[30:0], 1'b0};
        if (rem_w >= {1'b0, opb_q}) begin
          rem_w      = rem_w - {1'b0, opb_q};
          step_lo[0] = 1'b1;
        end
        step_hi = rem_w[31:0];
      end else begin
        sum_w = step_lo[0] ? ({1'b0, step_hi} + {1'b0, opb_q}) : {1'b0, step_hi};
        {step_hi, step_lo} = {sum_w, step_lo[31:1]};
      end
    end
  end

  // Sign fix-up of the final step's result, registered on entry to DONE.
  logic [63:0] prod;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;
  always_comb begin
    prod   = {step_hi, step_lo};
    fix_hi = step_hi;
    fix_lo = step_lo;
    if (is_div_q) begin
      fix_lo = neg_q ? (32'd0 - step_lo) : step_lo;
      fix_hi = rem_neg_q ? (32'd0 - step_hi) : step_hi;
    end else begin
      if (neg_q) prod = 64'd0 - prod;
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end
  end

  // Sequencer FSM with registered datapath and HI/LO write outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opb_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      we_q      <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            is_div_q  <= op[1];
            neg_q     <= signed_op && (operand_a[31] ^ operand_b[31]);
            rem_neg_q <= op[1] && signed_op && operand_a[31];
            opb_q     <= op[1] ? mag_b : mag_a;
            acc_hi_q  <= '0;
            acc_lo_q  <= op[1] ? mag_a : mag_b;
            if (is_dbz) begin
              // Divide by zero bypasses COMPUTE entirely.
              state_q <= S_DONE;
              we_q    <= 1'b1;
              dbz_q   <= 1'b1;
              hi_q    <= operand_a;
              lo_q    <= 32'hFFFF_FFFF;
            end else begin
              state_q <= S_COMPUTE;
            end
          end
        end
        S_COMPUTE: begin
          cnt_q    <= cnt_q + 5'd1;
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            we_q    <= 1'b1;
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          dbz_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          dbz_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy                        = (state_q != S_IDLE);
  assign stall                       = busy && (start || hi_lo_read_request);
  assign hi_lo_register_write_enable = we_q;
  assign HI_write_data               = hi_q;
  assign LO_write_data               = lo_q;
  assign div_by_zero                 = dbz_q;
  assign state_dbg                   = state_q;

endmodule
